// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised inter-stage pipeline register
// Adds stall/hold, flush bubbles, Tnew aging and bubble/stall counters.
module pipe_stage_reg #(
  parameter int DATA_W          = 32,
  parameter int NUM_CH          = 4,
  parameter int TNEW_W          = 3,
  parameter int CNT_W           = 16,
  parameter int CLEAR_ON_BUBBLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_instr,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic [NUM_CH*DATA_W-1:0] in_ch,
  input  logic [4:0]               in_wa,
  input  logic                     in_we,
  input  logic [TNEW_W-1:0]        in_tnew,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_instr,
  output logic [DATA_W-1:0]        out_pc,
  output logic [NUM_CH*DATA_W-1:0] out_ch,
  output logic [4:0]               out_wa,
  output logic                     out_we,
  output logic [TNEW_W-1:0]        out_tnew,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic                     validQ;
  logic [DATA_W-1:0]        instrQ;
  logic [DATA_W-1:0]        pcQ;
  logic [NUM_CH*DATA_W-1:0] chQ;
  logic [4:0]               waQ;
  logic                     weQ;
  logic [TNEW_W-1:0]        tnewQ;
  logic [CNT_W-1:0]         bubbleCntQ;
  logic [CNT_W-1:0]         stallCntQ;
  logic                     loadBubble;

  function automatic logic [TNEW_W-1:0] satDec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // An empty upstream slot with no stall is indistinguishable from a flush.
  assign loadBubble = flush | (~stall & ~in_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      validQ     <= 1'b0;
      instrQ     <= '0;
      pcQ        <= '0;
      chQ        <= '0;
      waQ        <= '0;
      weQ        <= 1'b0;
      tnewQ      <= '0;
      bubbleCntQ <= '0;
      stallCntQ  <= '0;
    end else if (loadBubble) begin
      validQ     <= 1'b0;
      instrQ     <= '0;
      waQ        <= '0;
      weQ        <= 1'b0;
      tnewQ      <= '0;
      if (CLEAR_ON_BUBBLE != 0) begin
        pcQ <= '0;
        chQ <= '0;
      end
      bubbleCntQ <= bubbleCntQ + CNT_W'(1);
    end else if (stall) begin
      tnewQ      <= satDec(tnewQ);
      stallCntQ  <= stallCntQ + CNT_W'(1);
    end else begin
      validQ     <= 1'b1;
      instrQ     <= in_instr;
      pcQ        <= in_pc;
      chQ        <= in_ch;
      waQ        <= in_wa;
      weQ        <= in_we;
      tnewQ      <= satDec(in_tnew);
    end
  end

  assign out_valid  = validQ;
  assign out_instr  = instrQ;
  assign out_pc     = pcQ;
  assign out_ch     = chQ;
  assign out_wa     = validQ ? waQ : 5'd0;
  assign out_we     = validQ & weQ & (waQ != 5'd0);
  assign out_tnew   = tnewQ;
  assign bubble_cnt = bubbleCntQ;
  assign stall_cnt  = stallCntQ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
// dut1: CLEAR_ON_BUBBLE=1, CNT_W=4; dut0: CLEAR_ON_BUBBLE=0, CNT_W=16.
module tb_pipe_stage_reg;

  logic         clk;
  logic         reset, stall, flush, inValid, inWe;
  logic [31:0]  inInstr, inPc;
  logic [127:0] inCh;
  logic [4:0]   inWa;
  logic [2:0]   inTnew;

  logic         aValid, aWe, bValid, bWe;
  logic [31:0]  aInstr, aPc, bInstr, bPc;
  logic [127:0] aCh, bCh;
  logic [4:0]   aWa, bWa;
  logic [2:0]   aTnew, bTnew;
  logic [3:0]   aBub, aStl;
  logic [15:0]  bBub, bStl;

  int nChecks = 0;
  int nFails  = 0;

  pipe_stage_reg #(.CNT_W(4), .CLEAR_ON_BUBBLE(1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(inValid),
    .in_instr(inInstr), .in_pc(inPc), .in_ch(inCh), .in_wa(inWa), .in_we(inWe),
    .in_tnew(inTnew), .out_valid(aValid), .out_instr(aInstr), .out_pc(aPc),
    .out_ch(aCh), .out_wa(aWa), .out_we(aWe), .out_tnew(aTnew),
    .bubble_cnt(aBub), .stall_cnt(aStl));

  pipe_stage_reg #(.CNT_W(16), .CLEAR_ON_BUBBLE(0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(inValid),
    .in_instr(inInstr), .in_pc(inPc), .in_ch(inCh), .in_wa(inWa), .in_we(inWe),
    .in_tnew(inTnew), .out_valid(bValid), .out_instr(bInstr), .out_pc(bPc),
    .out_ch(bCh), .out_wa(bWa), .out_we(bWe), .out_tnew(bTnew),
    .bubble_cnt(bBub), .stall_cnt(bStl));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int v, input logic [127:0] act,
                       input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s (variant %0d) at %0t: actual=%0h required=%0h", name, v, $time, act, exp);
    end
  endtask

  // Model: index 0 = clearing variant with 16-wrap counters, 1 = keeping variant with 65536-wrap.
  bit           mInit = 0;
  bit           mValid [2];
  logic [31:0]  mInstr [2];
  logic [31:0]  mPc    [2];
  logic [127:0] mCh    [2];
  int           mWa    [2];
  bit           mWe    [2];
  int           mTnew  [2];
  int           mBub   [2];
  int           mStl   [2];
  int           cntMod [2] = '{16, 65536};

  always @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (reset) begin
        mValid[v] = 0; mInstr[v] = 0; mPc[v] = 0; mCh[v] = 0;
        mWa[v] = 0; mWe[v] = 0; mTnew[v] = 0; mBub[v] = 0; mStl[v] = 0;
      end else if (flush || (!stall && !inValid)) begin
        mValid[v] = 0; mInstr[v] = 0; mWa[v] = 0; mWe[v] = 0; mTnew[v] = 0;
        if (v == 0) begin mPc[v] = 0; mCh[v] = 0; end
        mBub[v] = (mBub[v] + 1) % cntMod[v];
      end else if (stall) begin
        mTnew[v] = (mTnew[v] > 0) ? mTnew[v] - 1 : 0;
        mStl[v] = (mStl[v] + 1) % cntMod[v];
      end else begin
        mValid[v] = 1; mInstr[v] = inInstr; mPc[v] = inPc; mCh[v] = inCh;
        mWa[v] = int'(inWa); mWe[v] = inWe;
        mTnew[v] = (int'(inTnew) > 0) ? int'(inTnew) - 1 : 0;
      end
    end
    if (reset) mInit = 1;
  end

  task automatic cmpDut(input int v, input logic valid, input logic [31:0] instr,
                        input logic [31:0] pc, input logic [127:0] ch, input logic [4:0] wa,
                        input logic we, input logic [2:0] tnew, input logic [15:0] bub,
                        input logic [15:0] stl);
    check("valid", v, 128'(valid), 128'(mValid[v]));
    check("instr", v, 128'(instr), 128'(mInstr[v]));
    check("pc",    v, 128'(pc),    128'(mPc[v]));
    check("ch",    v, ch,          mCh[v]);
    check("wa",    v, 128'(wa),    mValid[v] ? 128'(mWa[v]) : 128'd0);
    check("we",    v, 128'(we),    128'(mValid[v] && mWe[v] && mWa[v] != 0));
    check("tnew",  v, 128'(tnew),  128'(mTnew[v]));
    check("bubble_cnt", v, 128'(bub), 128'(mBub[v]));
    check("stall_cnt",  v, 128'(stl), 128'(mStl[v]));
  endtask

  always @(negedge clk) begin
    if (mInit) begin
      cmpDut(0, aValid, aInstr, aPc, aCh, aWa, aWe, aTnew, {12'd0, aBub}, {12'd0, aStl});
      cmpDut(1, bValid, bInstr, bPc, bCh, bWa, bWe, bTnew, bBub, bStl);
    end
  end

  // Inputs change on the falling edge; returns just after the following rising edge.
  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic [127:0] ch, input logic [4:0] wa, input logic we,
                       input logic [2:0] tnew);
    @(negedge clk);
    reset = r; stall = s; flush = f; inValid = v; inInstr = instr; inPc = pc;
    inCh = ch; inWa = wa; inWe = we; inTnew = tnew;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] CH4 = 128'h44444444_33333333_22222222_11111111;

  initial begin
    reset = 1; stall = 0; flush = 0; inValid = 0; inInstr = 0; inPc = 0;
    inCh = 0; inWa = 0; inWe = 0; inTnew = 0;

    drive(1, 0, 0, 1, 32'hDEADBEEF, 32'h1234, CH4, 5'd3, 1, 3'd5);
    check("reset valid", 0, 128'(aValid), 128'd0);
    check("reset pc", 1, 128'(bPc), 128'd0);
    check("reset ch", 0, aCh, 128'd0);

    drive(0, 0, 0, 1, 32'h8C080004, 32'h3000, CH4, 5'd8, 1, 3'd2);
    check("lw valid", 0, 128'(aValid), 128'd1);
    check("lw pc", 0, 128'(aPc), 128'h3000);
    check("lw tnew", 0, 128'(aTnew), 128'd1);
    check("lw we", 0, 128'(aWe), 128'd1);

    drive(0, 1, 0, 1, 32'hFFFFFFFF, 32'h4444, 128'd7, 5'd9, 0, 3'd7);
    check("stall1 tnew", 0, 128'(aTnew), 128'd0);
    drive(0, 1, 0, 0, 32'h0, 32'h5555, 128'd9, 5'd1, 1, 3'd3);
    drive(0, 1, 0, 1, 32'h1, 32'h6666, 128'd3, 5'd2, 1, 3'd4);
    check("stall3 tnew", 0, 128'(aTnew), 128'd0);
    check("stall3 pc", 0, 128'(aPc), 128'h3000);
    check("stall3 instr", 0, 128'(aInstr), 128'h8C080004);
    check("stall3 cnt", 0, 128'(aStl), 128'd3);

    drive(0, 1, 1, 1, 32'h2, 32'h7777, 128'd5, 5'd4, 1, 3'd1);
    check("flush valid", 0, 128'(aValid), 128'd0);
    check("flush instr", 0, 128'(aInstr), 128'd0);
    check("flush ch", 0, aCh, 128'd0);
    check("flush we", 0, 128'(aWe), 128'd0);
    check("flush bub", 0, 128'(aBub), 128'd1);
    check("flush stl", 0, 128'(aStl), 128'd3);
    check("keep ch", 1, bCh, CH4);
    check("keep pc", 1, 128'(bPc), 128'h3000);
    check("keep valid", 1, 128'(bValid), 128'd0);

    drive(0, 0, 0, 1, 32'h20000001, 32'h3004, 128'd1, 5'd0, 1, 3'd0);
    check("r0 we", 0, 128'(aWe), 128'd0);
    check("r0 valid", 0, 128'(aValid), 128'd1);
    check("r0 tnew sat", 0, 128'(aTnew), 128'd0);

    drive(0, 0, 0, 1, 32'h00851020, 32'h3008, CH4, 5'd31, 1, 3'd7);
    check("tnew7", 0, 128'(aTnew), 128'd6);
    drive(0, 0, 0, 0, 32'h00851020, 32'h300C, CH4, 5'd31, 1, 3'd7);
    check("idle bubble valid", 0, 128'(aValid), 128'd0);
    check("idle bubble cnt", 0, 128'(aBub), 128'd2);

    drive(1, 0, 0, 0, 32'h0, 32'h0, 128'd0, 5'd0, 0, 3'd0);
    for (int i = 0; i < 17; i++)
      drive(0, 0, (i % 3) == 0, 0, 32'(i), 32'(i * 4), 128'(i), 5'(i), 1, 3'(i));
    check("wrap bub4", 0, 128'(aBub), 128'd1);
    check("wrap bub16", 1, 128'(bBub), 128'd17);

    drive(0, 0, 0, 1, 32'hAC090008, 32'h3010, CH4, 5'd9, 0, 3'd3);
    drive(0, 1, 0, 1, 32'h0, 32'h0, 128'd0, 5'd0, 0, 3'd0);
    drive(1, 1, 0, 1, 32'h1, 32'h1, 128'd1, 5'd1, 1, 3'd1);
    check("rst valid", 0, 128'(aValid), 128'd0);
    check("rst pc", 1, 128'(bPc), 128'd0);
    check("rst ch", 1, bCh, 128'd0);
    check("rst tnew", 0, 128'(aTnew), 128'd0);
    check("rst bub", 1, 128'(bBub), 128'd0);
    check("rst stl", 0, 128'(aStl), 128'd0);

    drive(0, 0, 0, 1, 32'h8C0A0010, 32'h3020, CH4, 5'd10, 1, 3'd1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 128'd0, 5'd0, 0, 3'd0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the MIPS pipeline; replaces the hand-written per-stage latches (D/E, E/M, M/W).
- Carries instr, PC, N packed data channels, register-write info and a hazard Tnew counter.
- Adds stall/hold, flush/bubble insertion, a valid bit, Tnew aging while held, and a bubble/stall performance counter.

Parameters:
- DATA_W, 32, width of instr, PC and each data channel
- NUM_CH, 4, number of data channels (e.g. RD1, RD2, aluRes, extRes)
- TNEW_W, 3, Tnew field width
- CNT_W, 16, performance counter width
- CLEAR_ON_BUBBLE, 1, 1: bubble zeroes PC and channels; 0: PC and channels keep their old values

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold current contents
- flush  in  1  load a bubble
- in_valid  in  1  upstream slot holds a real instruction
- in_instr  in  DATA_W  instruction
- in_pc  in  DATA_W  PC
- in_ch  in  NUM_CH*DATA_W  packed channels; ch k = bits [k*DATA_W +: DATA_W]
- in_wa  in  5  destination register
- in_we  in  1  register write enable
- in_tnew  in  TNEW_W  Tnew of the instruction in the upstream stage
- out_valid  out  1  registered valid
- out_instr  out  DATA_W  registered instr
- out_pc  out  DATA_W  registered PC
- out_ch  out  NUM_CH*DATA_W  registered channels
- out_wa  out  5  registered write address; 0 when !out_valid
- out_we  out  1  out_valid & registered we & (out_wa != 0)
- out_tnew  out  TNEW_W  current Tnew
- bubble_cnt  out  CNT_W  count of bubble cycles loaded
- stall_cnt  out  CNT_W  count of stalled cycles

Behaviour:
- All state updates on posedge clk. Priority: reset > flush > stall > load.
- Reset:
  - out_valid=0, out_instr=0 (NOP), out_pc=0, out_ch=0, out_wa=0, out_tnew=0, both counters=0.
- Flush (stall ignored):
  - Loads a bubble: valid=0, instr=0, wa=0, we=0, tnew=0.
  - PC and channels are zeroed if CLEAR_ON_BUBBLE=1, otherwise unchanged.
  - bubble_cnt increments.
- Stall (no flush):
  - All fields hold.
  - out_tnew decrements by 1 per cycle, saturating at 0, so a held multi-cycle op matures.
  - stall_cnt increments.
- Load (neither stall nor flush):
  - If in_valid=1: capture all inputs; out_tnew = in_tnew-1, saturating at 0.
  - If in_valid=0: treated exactly as a bubble load, and bubble_cnt increments.
- Counters wrap modulo 2^CNT_W. They are not cleared by flush.
- Single-cycle latency input to output; no combinational path from any input to any output.
- out_we is combinational from registered state only. Writes to $0 never assert out_we.
- Reset during a stall or flush clears everything in that cycle.
- Simultaneous flush and stall counts as a bubble only; stall_cnt does not increment.

Test Plan:
- Reset, then load in_valid=1, instr=0x8C080004 (lw), pc=0x3000, wa=8, we=1, tnew=2 -> next cycle: out_valid=1, out_pc=0x3000, out_tnew=1, out_we=1.
- Same instruction held with stall=1 for 3 cycles -> out_tnew goes 1,0,0; all other fields unchanged; stall_cnt=3.
- flush=1 together with stall=1 while holding a valid instr (CLEAR_ON_BUBBLE=1) -> out_valid=0, out_instr=0, out_ch=0, out_we=0; bubble_cnt+1, stall_cnt unchanged.
- Load valid instr with wa=0, we=1 -> out_we=0, out_valid=1.
- NUM_CH=4, channels 0x11111111..0x44444444, then a bubble with CLEAR_ON_BUBBLE=0 -> out_ch retains the same four values, out_valid=0.
- CNT_W=4, 17 bubble loads -> bubble_cnt=1 (wrap); then assert reset mid-stall -> all outputs 0 the next cycle.
